// File: rtl/sfp_accum.sv
// Output-stationary partial-sum accumulator: reads num_kij psum words per output row from the
// OP SRAM, sums them lane-wise and writes one final word per row. Define SFP_RELU_EN to clamp negative lanes to 0.
module sfp_accum #(
    parameter int col     = 8,
    parameter int psum_bw = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [8:0]               psum_base,
    input  logic [8:0]               out_base,
    input  logic [4:0]               num_out,
    input  logic [3:0]               num_kij,
    input  logic [col*psum_bw-1:0]   OP_q,
    output logic                     OP_cen,
    output logic                     OP_wen,
    output logic [8:0]               OP_addr,
    output logic [col*psum_bw-1:0]   OP_d,
    output logic                     busy,
    output logic                     done
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RD       = 3'd1,
        ACC_LAST = 3'd2,
        WR       = 3'd3,
        FIN      = 3'd4
    } state_t;

    typedef logic [col-1:0][psum_bw-1:0] lanes_t;

    state_t      state_q, state_d;
    logic [8:0]  psum_base_q, psum_base_d;
    logic [8:0]  out_base_q, out_base_d;
    logic [4:0]  num_out_q, num_out_d;
    logic [3:0]  num_kij_q, num_kij_d;
    logic [4:0]  o_q, o_d;
    logic [3:0]  k_q, k_d;
    logic [8:0]  ptr_q, ptr_d;
    logic [8:0]  row_ptr_q, row_ptr_d;
    logic        rd_pend_q, rd_pend_d;
    lanes_t      acc_q, acc_d;
    lanes_t      acc_sum, wr_data;

    logic                   op_cen_q, op_cen_d;
    logic                   op_wen_q, op_wen_d;
    logic [8:0]             op_addr_q, op_addr_d;
    logic [col*psum_bw-1:0] op_d_q, op_d_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;

    // Read data arrives the cycle after each RD, so the add is keyed off rd_pend_q rather than the state.
    always_comb begin
        for (int i = 0; i < col; i++) begin
            acc_sum[i] = rd_pend_q ? acc_q[i] + OP_q[i*psum_bw +: psum_bw] : acc_q[i];
`ifdef SFP_RELU_EN
            wr_data[i] = acc_sum[i][psum_bw-1] ? '0 : acc_sum[i];
`else
            wr_data[i] = acc_sum[i];
`endif
        end
    end

    // NOTE: every *_d gets a default from its *_q first so no path through the case infers a latch.
    always_comb begin
        state_d     = state_q;
        psum_base_d = psum_base_q;
        out_base_d  = out_base_q;
        num_out_d   = num_out_q;
        num_kij_d   = num_kij_q;
        o_d         = o_q;
        k_d         = k_q;
        ptr_d       = ptr_q;
        row_ptr_d   = row_ptr_q;
        acc_d       = acc_sum;
        rd_pend_d   = (state_q == RD);

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    psum_base_d = psum_base;
                    out_base_d  = out_base;
                    num_out_d   = num_out;
                    num_kij_d   = num_kij;
                    o_d         = '0;
                    k_d         = '0;
                    ptr_d       = psum_base;
                    row_ptr_d   = psum_base;
                    acc_d       = '0;
                    state_d     = (num_out == 5'd0 || num_kij == 4'd0) ? FIN : RD;
                end
            end
            RD: begin
                k_d   = k_q + 4'd1;
                ptr_d = ptr_q + {4'b0, num_out_q};
                if (k_q == num_kij_q - 4'd1) begin
                    state_d = ACC_LAST;
                end
            end
            ACC_LAST: begin
                state_d = WR;
            end
            WR: begin
                acc_d     = '0;
                k_d       = '0;
                o_d       = o_q + 5'd1;
                row_ptr_d = row_ptr_q + 9'd1;
                ptr_d     = row_ptr_q + 9'd1;
                state_d   = ({1'b0, o_q} + 6'd1 < {1'b0, num_out_q}) ? RD : FIN;
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: outputs are decoded from the next state so the registered copies line up with the state they describe.
    always_comb begin
        op_cen_d  = 1'b1;
        op_wen_d  = 1'b1;
        op_addr_d = '0;
        op_d_d    = '0;
        unique case (state_d)
            RD: begin
                op_cen_d  = 1'b0;
                op_addr_d = ptr_d;
            end
            WR: begin
                op_cen_d  = 1'b0;
                op_wen_d  = 1'b0;
                op_addr_d = out_base_q + {4'b0, o_q};
                op_d_d    = wr_data;
            end
            default: begin
                op_cen_d = 1'b1;
            end
        endcase
        busy_d = (state_d == RD) || (state_d == ACC_LAST) || (state_d == WR);
        done_d = (state_d == FIN);
    end

    // NOTE: the lane accumulators are plain flops, not an SRAM, so they are cleared by reset along with the rest.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            psum_base_q <= '0;
            out_base_q  <= '0;
            num_out_q   <= '0;
            num_kij_q   <= '0;
            o_q         <= '0;
            k_q         <= '0;
            ptr_q       <= '0;
            row_ptr_q   <= '0;
            rd_pend_q   <= 1'b0;
            acc_q       <= '0;
            op_cen_q    <= 1'b1;
            op_wen_q    <= 1'b1;
            op_addr_q   <= '0;
            op_d_q      <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            psum_base_q <= psum_base_d;
            out_base_q  <= out_base_d;
            num_out_q   <= num_out_d;
            num_kij_q   <= num_kij_d;
            o_q         <= o_d;
            k_q         <= k_d;
            ptr_q       <= ptr_d;
            row_ptr_q   <= row_ptr_d;
            rd_pend_q   <= rd_pend_d;
            acc_q       <= acc_d;
            op_cen_q    <= op_cen_d;
            op_wen_q    <= op_wen_d;
            op_addr_q   <= op_addr_d;
            op_d_q      <= op_d_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign OP_cen  = op_cen_q;
    assign OP_wen  = op_wen_q;
    assign OP_addr = op_addr_q;
    assign OP_d    = op_d_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule

// File: tb/tb_sfp_accum.sv
// Self-checking bench for sfp_accum: an SRAM model, a cycle-schedule reference model checked every
// cycle, and directed scenarios with hand-computed results.
module tb_sfp_accum;

    localparam int COL = 8;
    localparam int BW  = 16;
    localparam int WW  = COL * BW;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [8:0]    psum_base;
    logic [8:0]    out_base;
    logic [4:0]    num_out;
    logic [3:0]    num_kij;
    logic [WW-1:0] OP_q;
    logic          OP_cen;
    logic          OP_wen;
    logic [8:0]    OP_addr;
    logic [WW-1:0] OP_d;
    logic          busy;
    logic          done;

    always #5 clk = ~clk;

    sfp_accum #(.col(COL), .psum_bw(BW)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .psum_base (psum_base),
        .out_base  (out_base),
        .num_out   (num_out),
        .num_kij   (num_kij),
        .OP_q      (OP_q),
        .OP_cen    (OP_cen),
        .OP_wen    (OP_wen),
        .OP_addr   (OP_addr),
        .OP_d      (OP_d),
        .busy      (busy),
        .done      (done)
    );

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    task automatic check(input string name, input logic [WW-1:0] act, input logic [WW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // SRAM with one-cycle read latency
    logic [WW-1:0] mem [512];
    int            rd_log[$];

    always @(posedge clk) begin
        if (OP_cen === 1'b0) begin
            if (OP_wen === 1'b0) begin
                mem[OP_addr] = OP_d;
            end else begin
                OP_q <= mem[OP_addr];
                rd_log.push_back(int'(OP_addr));
            end
        end
    end

    function automatic logic [WW-1:0] splat(input int v);
        logic [WW-1:0] r;
        for (int l = 0; l < COL; l++) r[l*BW +: BW] = BW'(v);
        return r;
    endfunction

    // Reference result for one output row, straight from the summation rule.
    function automatic logic [WW-1:0] exp_word(input int pb, input int no, input int nk, input int row);
        logic [WW-1:0] r;
        logic [BW-1:0] s;
        r = '0;
        for (int l = 0; l < COL; l++) begin
            s = '0;
            for (int k = 0; k < nk; k++) s = s + mem[(pb + k*no + row) % 512][l*BW +: BW];
`ifdef SFP_RELU_EN
            if (s[BW-1]) s = '0;
`endif
            r[l*BW +: BW] = s;
        end
        return r;
    endfunction

    // Schedule model: t counts cycles since the start cycle; each row is nk reads, one idle, one write.
    bit m_active = 1'b0;
    int m_t, m_T, m_pb, m_ob, m_no, m_nk;

    always @(posedge clk) begin
        if (reset === 1'b1) begin
            m_active = 1'b0;
        end else if (m_active) begin
            if (m_t == m_T) m_active = 1'b0;
            else m_t++;
        end else if (start === 1'b1) begin
            m_active = 1'b1;
            m_t  = 1;
            m_pb = int'(psum_base);
            m_ob = int'(out_base);
            m_no = int'(num_out);
            m_nk = int'(num_kij);
            m_T  = (m_no == 0 || m_nk == 0) ? 1 : m_no * (m_nk + 2) + 1;
        end
    end

    always @(negedge clk) begin : cmp
        int row, pos;
        if (chk_en) begin
            if (!m_active) begin
                check("idle_cen",  WW'(OP_cen), WW'(1));
                check("idle_wen",  WW'(OP_wen), WW'(1));
                check("idle_busy", WW'(busy),   WW'(0));
                check("idle_done", WW'(done),   WW'(0));
            end else if (m_t == m_T) begin
                check("fin_done", WW'(done),   WW'(1));
                check("fin_busy", WW'(busy),   WW'(0));
                check("fin_cen",  WW'(OP_cen), WW'(1));
                check("fin_wen",  WW'(OP_wen), WW'(1));
            end else begin
                row = (m_t - 1) / (m_nk + 2);
                pos = (m_t - 1) % (m_nk + 2);
                check("run_busy", WW'(busy), WW'(1));
                check("run_done", WW'(done), WW'(0));
                if (pos < m_nk) begin
                    check("rd_cen",  WW'(OP_cen),  WW'(0));
                    check("rd_wen",  WW'(OP_wen),  WW'(1));
                    check("rd_addr", WW'(OP_addr), WW'((m_pb + pos*m_no + row) % 512));
                end else if (pos == m_nk) begin
                    check("acc_cen", WW'(OP_cen), WW'(1));
                    check("acc_wen", WW'(OP_wen), WW'(1));
                end else begin
                    check("wr_cen",  WW'(OP_cen),  WW'(0));
                    check("wr_wen",  WW'(OP_wen),  WW'(0));
                    check("wr_addr", WW'(OP_addr), WW'((m_ob + row) % 512));
                    check("wr_data", OP_d, exp_word(m_pb, m_no, m_nk, row));
                end
            end
        end
    end

    // Called at posedge+1; leaves the bench at posedge+1 of the cycle after the start cycle.
    task automatic do_start(input int pb, input int ob, input int no, input int nk);
        psum_base = 9'(pb);
        out_base  = 9'(ob);
        num_out   = 5'(no);
        num_kij   = 4'(nk);
        start     = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int limit, input int exp_n);
        int n;
        n = -1;
        for (int i = 1; i <= limit; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                n = i;
                break;
            end
        end
        check(name, WW'(n), WW'(exp_n));
        @(posedge clk);
        #1;
    endtask

    initial begin : timeout
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int dcount, dcyc;
        logic [WW-1:0] w;
        reset = 1'b1; start = 1'b0;
        psum_base = '0; out_base = '0; num_out = '0; num_kij = '0;
        for (int a = 0; a < 512; a++) mem[a] = '0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_cen",  WW'(OP_cen),  WW'(1));
        check("rst_wen",  WW'(OP_wen),  WW'(1));
        check("rst_addr", WW'(OP_addr), WW'(0));
        check("rst_d",    OP_d,         WW'(0));
        check("rst_busy", WW'(busy),    WW'(0));
        check("rst_done", WW'(done),    WW'(0));
        chk_en = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk);
        #1;

        // Two rows of three kernel positions: 1+3+5 and 2+4+6
        for (int a = 0; a < 6; a++) mem[a] = splat(a + 1);
        check("model_row0", exp_word(0, 2, 3, 0), splat(9));
        check("model_row1", exp_word(0, 2, 3, 1), splat(12));
        do_start(0, 100, 2, 3);
        wait_done("req034_done_cycle", 40, 11);
        check("req034_w100", mem[100], splat(9));
        check("req034_w101", mem[101], splat(12));

        // Negative lane sum of -5
        w = splat(1); w[15:0] = 16'hFFFE; mem[200] = w;
        w = splat(2); w[15:0] = 16'hFFFD; mem[201] = w;
        do_start(200, 300, 1, 2);
        wait_done("req035_done_cycle", 20, 5);
`ifdef SFP_RELU_EN
        check("req035_lane0", WW'(mem[300][15:0]), WW'(16'h0000));
`else
        check("req035_lane0", WW'(mem[300][15:0]), WW'(16'hFFFB));
`endif
        check("req035_lane1", WW'(mem[300][31:16]), WW'(16'd3));

        // Zero counts: immediate done, no SRAM access
        rd_log.delete();
        do_start(0, 120, 3, 0);
        wait_done("req036_kij0_done", 10, 1);
        do_start(0, 121, 0, 3);
        wait_done("req036_out0_done", 10, 1);
        check("req036_no_reads", WW'(rd_log.size()), WW'(0));
        check("req036_no_write", mem[120], WW'(0));

        // Address wraparound
        mem[510] = splat(7);
        mem[511] = splat(8);
        rd_log.delete();
        do_start(510, 130, 1, 3);
        wait_done("req037_done_cycle", 20, 6);
        check("req037_nreads", WW'(rd_log.size()), WW'(3));
        if (rd_log.size() == 3) begin
            check("req037_rd0", WW'(rd_log[0]), WW'(510));
            check("req037_rd1", WW'(rd_log[1]), WW'(511));
            check("req037_rd2", WW'(rd_log[2]), WW'(0));
        end
        check("req037_w130", mem[130], splat(16));

        // Reset (with start also high) in the 4th RD cycle
        do_start(0, 140, 1, 5);
        repeat (3) @(posedge clk);
        #1 reset = 1'b1; start = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0; start = 1'b0;
        @(negedge clk);
        check("req038_busy", WW'(busy),   WW'(0));
        check("req038_cen",  WW'(OP_cen), WW'(1));
        check("req038_done", WW'(done),   WW'(0));
        dcount = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done === 1'b1) dcount++;
        end
        check("req038_no_done", WW'(dcount), WW'(0));
        check("req038_no_write", mem[140], WW'(0));
        @(posedge clk);
        #1;

        // Start re-pulsed during the pass and in the done cycle
        do_start(0, 150, 2, 3);
        dcount = 0; dcyc = -1;
        for (int i = 1; i <= 20; i++) begin
            if (i == 3 || i == 10 || i == 11) begin
                psum_base = 9'd200; out_base = 9'd160; num_out = 5'd1; num_kij = 4'd2;
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            if (done === 1'b1) begin
                dcount++;
                dcyc = i;
            end
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        check("req039_ndone",  WW'(dcount), WW'(1));
        check("req039_dcycle", WW'(dcyc),   WW'(11));
        check("req039_w150",   mem[150],    splat(9));
        check("req039_w151",   mem[151],    splat(12));
        check("req039_no_w160", mem[160],   WW'(0));

        repeat (2) @(posedge clk);
        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sfp_accum.md
SFP_ACCUM -- requirements
Module: sfp_accum

Interface
REQ-001: The block SHALL have parameter col, default 8, giving the number of output lanes per OP SRAM word.
REQ-002: The block SHALL have parameter psum_bw, default 16, giving the signed partial-sum width per lane; OP word width = col*psum_bw = 128.
REQ-003: clk  input  1  sole clock; all state updates on its rising edge.
REQ-004: reset  input  1  synchronous, active-high reset.
REQ-005: start  input  1  single-cycle request to begin an accumulation pass.
REQ-006: psum_base  input  9  OP SRAM address of the first partial-sum word.
REQ-007: out_base  input  9  OP SRAM address of the first final-output word.
REQ-008: num_out  input  5  number of output rows per pass (0..31).
REQ-009: num_kij  input  4  number of kernel positions accumulated per output row (0..15).
REQ-010: OP_q  input  col*psum_bw  OP SRAM read data; valid one cycle after a read is issued.
REQ-011: OP_cen  output  1  OP SRAM chip enable, active low.
REQ-012: OP_wen  output  1  OP SRAM write enable, active low.
REQ-013: OP_addr  output  9  OP SRAM address.
REQ-014: OP_d  output  col*psum_bw  OP SRAM write data.
REQ-015: busy  output  1  high while a pass is in progress.
REQ-016: done  output  1  single-cycle pulse when a pass completes.

Function
REQ-017: States SHALL be IDLE, RD, ACC_LAST, WR and FIN.
REQ-018: In IDLE, start=1 SHALL latch psum_base, out_base, num_out and num_kij, clear output index o, kernel index k and all lane accumulators, and enter RD; if the latched num_out or num_kij is 0, the next state SHALL be FIN instead.
REQ-019: start SHALL be ignored in every state except IDLE.
REQ-020: In RD, the block SHALL issue a read with OP_cen=0, OP_wen=1 and OP_addr=(psum_base + k*num_out + o) mod 512, then increment k.
REQ-021: The block SHALL compute the read address with a running pointer (add num_out per k), not with a multiplier.
REQ-022: After the read with k=num_kij-1, the block SHALL enter ACC_LAST.
REQ-023: In each cycle following a read, the block SHALL add every psum_bw lane of OP_q to the matching signed lane accumulator with two's-complement wraparound at psum_bw bits; the first such add SHALL use a zeroed accumulator.
REQ-024: ACC_LAST SHALL perform the final add with OP_cen=1 and then enter WR.
REQ-025: In WR, the block SHALL drive OP_cen=0, OP_wen=0, OP_addr=(out_base+o) mod 512 and OP_d = the accumulator lanes after the output function, clear the accumulators, reset k to 0 and increment o.
REQ-026: From WR, the block SHALL enter RD if o < num_out, else FIN.
REQ-027: FIN SHALL assert done for exactly one cycle and return to IDLE.
REQ-028: Each output row SHALL take num_kij+2 cycles; done SHALL rise num_out*(num_kij+2)+1 cycles after the start cycle, or 1 cycle after it when either count is 0.
REQ-029: busy SHALL be 1 in RD, ACC_LAST and WR, and 0 in IDLE and FIN.
REQ-030: Outside RD and WR, OP_cen SHALL be 1 and OP_wen SHALL be 1; the block SHALL never issue a read and a write in the same cycle.

Reset
REQ-031: With reset=1 at a clock edge, the block SHALL enter IDLE and drive OP_cen=1, OP_wen=1, OP_addr=0, OP_d=0, busy=0 and done=0, and clear all counters and accumulators.
REQ-032: Reset mid-pass SHALL abort the pass with no further SRAM access and no done pulse; reset SHALL take priority over start in the same cycle.

Configuration
REQ-033: When SFP_RELU_EN is defined, each lane written in WR SHALL be clamped to 0 if negative; when it is undefined, the raw wrapped accumulator SHALL be written.

Verification
REQ-034: A bench SHALL check: num_out=2, num_kij=3, psum_base=0, out_base=100, all lanes of words 0..5 = 1..6 -> word 100 lanes = 1+3+5 = 9, word 101 lanes = 12, done at cycle 11 after start.
REQ-035: A bench SHALL check: one lane summing to -5, with SFP_RELU_EN -> lane written 0; without it -> lane written 0xFFFB.
REQ-036: A bench SHALL check: num_kij=0 and start -> done one cycle later, OP_cen held at 1 throughout.
REQ-037: A bench SHALL check: psum_base=510, num_out=1, num_kij=3 -> reads at addresses 510, 511 and 0.
REQ-038: A bench SHALL check: reset asserted during the 4th RD cycle -> next cycle state IDLE, OP_cen=1, busy=0, and no done pulse.
REQ-039: A bench SHALL check: start re-pulsed while busy -> ignored, with exactly one done pulse at the original scheduled cycle.
